// File: rtl/fft_bitrev_reorder_if.sv
// Streaming bundle for the FFT bit-reversal reorder stage: bit-reversed samples in,
// natural-order samples out, plus the sticky framing-error flag.
interface fft_bitrev_reorder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2N      = 4
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_r;
    logic signed [DATA_WIDTH-1:0] in_i;
    logic                         in_last;

    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_r;
    logic signed [DATA_WIDTH-1:0] out_i;
    logic [LOG2N-1:0]             out_idx;
    logic                         out_last;

    logic                         frame_err;

    // The reorder block is the slave of both streams' control direction.
    modport slave (
        input  in_valid, in_r, in_i, in_last, out_ready,
        output in_ready, out_valid, out_r, out_i, out_idx, out_last, frame_err
    );

    modport master (
        output in_valid, in_r, in_i, in_last, out_ready,
        input  in_ready, out_valid, out_r, out_i, out_idx, out_last, frame_err
    );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: writes each frame at bit-reversed addresses, reads it
// back sequentially so the downstream sees bins X[0]..X[N-1] in natural order.
module fft_bitrev_reorder #(
    parameter int DATA_WIDTH = 16,
    parameter int N_POINTS   = 16,
    parameter int LOG2N      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    fft_bitrev_reorder_if.slave bus
);
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    sample_t          mem_r [2][N_POINTS];
    sample_t          mem_i [2][N_POINTS];

    logic             wr_bank;
    logic             rd_bank;
    logic [LOG2N-1:0] wr_cnt;
    logic [LOG2N-1:0] rd_cnt;
    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic             frame_err_q;

    logic             wr_fire;
    logic             rd_fire;
    logic             wr_wrap;
    logic             rd_wrap;
    logic [LOG2N-1:0] wr_addr;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        for (int k = 0; k < LOG2N; k++) begin
            r[k] = x[LOG2N-1-k];
        end
        return r;
    endfunction

    assign wr_fire = bus.in_valid  & bus.in_ready;
    assign rd_fire = bus.out_valid & bus.out_ready;
    assign wr_wrap = wr_fire & (wr_cnt == LAST_IDX);
    assign rd_wrap = rd_fire & (rd_cnt == LAST_IDX);
    assign wr_addr = bitrev(wr_cnt);

    // Held low while reset is asserted so no sample is taken during reset.
    assign bus.in_ready  = rst_n & ~full[wr_bank];
    assign bus.out_valid = full[rd_bank];
    assign bus.out_r     = mem_r[rd_bank][rd_cnt];
    assign bus.out_i     = mem_i[rd_bank][rd_cnt];
    assign bus.out_idx   = rd_cnt;
    assign bus.out_last  = full[rd_bank] & (rd_cnt == LAST_IDX);
    assign bus.frame_err = frame_err_q;

    // A completing write and a draining read always hit different banks
    // (the write bank is empty, the read bank is full), so both updates apply.
    always_comb begin
        // NOTE: default assignment first so no path leaves full_nxt unassigned (no latch).
        full_nxt = full;
        if (wr_wrap) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_wrap) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    // NOTE: storage is cleared on reset so no stale frame can ever be read back;
    // this costs reset routing on every entry but the contents are part of the reset state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < N_POINTS; a++) begin
                    mem_r[b][a] <= '0;
                    mem_i[b][a] <= '0;
                end
            end
        end else if (wr_fire) begin
            mem_r[wr_bank][wr_addr] <= bus.in_r;
            mem_i[wr_bank][wr_addr] <= bus.in_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            full        <= '0;
            frame_err_q <= 1'b0;
        end else begin
            full <= full_nxt;

            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_wrap) begin
                    wr_bank <= ~wr_bank;
                end
                // in_last is advisory: a mismatch only flags, framing follows wr_cnt.
                if (bus.in_last != (wr_cnt == LAST_IDX)) begin
                    frame_err_q <= 1'b1;
                end
            end

            if (rd_fire) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_wrap) begin
                    rd_bank <= ~rd_bank;
                end
            end
        end
    end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder: table-driven first frame, scoreboard
// monitor for every output, and directed sequences for stalls, framing and reset.
module tb_fft_bitrev_reorder;
    localparam int DW = 16;
    localparam int N  = 16;
    localparam int LG = 4;

    typedef logic signed [DW-1:0] smp_t;

    typedef struct {
        smp_t          r;
        smp_t          i;
        logic [LG-1:0] idx;
        logic          last;
    } exp_t;

    typedef struct {
        smp_t          in_r;
        smp_t          in_i;
        logic          in_last;
        smp_t          exp_r;
        smp_t          exp_i;
        logic [LG-1:0] exp_idx;
        logic          exp_last;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fft_bitrev_reorder_if #(.DATA_WIDTH(DW), .LOG2N(LG)) bus ();

    fft_bitrev_reorder #(.DATA_WIDTH(DW), .N_POINTS(N), .LOG2N(LG)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    smp_t part_r[N];
    smp_t part_i[N];
    int   part_pos = 0;
    int   n_in = 0;
    int   n_out = 0;
    int   cyc = 0;
    int   first_hs = -1;
    int   last_hs = -1;
    bit   cap_en = 0;
    int   cap_n = 0;
    exp_t cap[N];
    bit   hold_v = 0;
    exp_t held;
    bit   drv_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LG-1:0] bitrev4(input logic [LG-1:0] x);
        logic [LG-1:0] r;
        for (int k = 0; k < LG; k++) r[k] = x[LG-1-k];
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard: inputs build a frame model, outputs are popped and compared.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            part_pos = 0;
            hold_v   = 0;
        end else begin
            if (hold_v) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_r",     bus.out_r,     held.r);
                check("hold_i",     bus.out_i,     held.i);
                check("hold_idx",   bus.out_idx,   held.idx);
                check("hold_last",  bus.out_last,  held.last);
            end
            hold_v    = bus.out_valid & ~bus.out_ready;
            held.r    = bus.out_r;
            held.i    = bus.out_i;
            held.idx  = bus.out_idx;
            held.last = bus.out_last;

            if (bus.in_valid && bus.in_ready) begin
                part_r[part_pos] = bus.in_r;
                part_i[part_pos] = bus.in_i;
                part_pos++;
                n_in++;
                if (part_pos == N) begin
                    for (int j = 0; j < N; j++) begin
                        e.r    = part_r[bitrev4(LG'(j))];
                        e.i    = part_i[bitrev4(LG'(j))];
                        e.idx  = LG'(j);
                        e.last = (j == N - 1);
                        exp_q.push_back(e);
                    end
                    part_pos = 0;
                end
            end

            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                if (cap_en && cap_n < N) begin
                    cap[cap_n].r    = bus.out_r;
                    cap[cap_n].i    = bus.out_i;
                    cap[cap_n].idx  = bus.out_idx;
                    cap[cap_n].last = bus.out_last;
                    cap_n++;
                end
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_r",    bus.out_r,    e.r);
                    check("sb_i",    bus.out_i,    e.i);
                    check("sb_idx",  bus.out_idx,  e.idx);
                    check("sb_last", bus.out_last, e.last);
                end
            end
        end
    end

    task automatic send(input smp_t r, input smp_t i, input logic last, output int waited);
        bit acc = 0;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_r     = r;
        bus.in_i     = i;
        bus.in_last  = last;
        while (!acc && waited < 300) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        bus.in_valid = 1'b0;
        if (!acc) check("send_timeout", acc, 1);
    endtask

    task automatic drive_k(input int k);
        bus.in_r    = smp_t'((k % N) * 8 + k / N);
        bus.in_i    = smp_t'(-k);
        bus.in_last = ((k % N) == N - 1);
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((exp_q.size() != 0 || bus.out_valid || part_pos != 0) && g < 2000) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("idle_timeout", g < 2000, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[N];
        int   w;
        int   base_out;
        int   acc_n;
        int   k;
        int   guard;
        bit   a;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_r      = '0;
        bus.in_i      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready",  bus.in_ready,  0);
        check("rst_out_r",     bus.out_r,     0);
        check("rst_frame_err", bus.frame_err, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("post_rst_in_ready",  bus.in_ready,  1);
        check("post_rst_out_valid", bus.out_valid, 0);
        check("post_rst_out_r",     bus.out_r,     0);
        check("post_rst_out_i",     bus.out_i,     0);
        check("post_rst_out_idx",   bus.out_idx,   0);
        check("post_rst_out_last",  bus.out_last,  0);
        check("post_rst_frame_err", bus.frame_err, 0);
        @(posedge clk);
        #1;

        // Single frame, table-driven
        for (int j = 0; j < N; j++) begin
            tbl[j].in_r     = smp_t'(j * 8);
            tbl[j].in_i     = smp_t'(-j);
            tbl[j].in_last  = (j == N - 1);
            tbl[j].exp_r    = smp_t'(int'(bitrev4(LG'(j))) * 8);
            tbl[j].exp_i    = smp_t'(-int'(bitrev4(LG'(j))));
            tbl[j].exp_idx  = LG'(j);
            tbl[j].exp_last = (j == N - 1);
        end
        bus.out_ready = 1'b1;
        cap_en = 1;
        cap_n  = 0;
        for (int j = 0; j < N; j++) begin
            send(tbl[j].in_r, tbl[j].in_i, tbl[j].in_last, w);
            if (j == N - 2) check("t1_not_valid_early", bus.out_valid, 0);
            if (j == N - 1) check("t1_valid_latency",   bus.out_valid, 1);
        end
        guard = 0;
        while (cap_n < N && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("t1_capture_count", cap_n, N);
        cap_en = 0;
        for (int j = 0; j < N; j++) begin
            check("t1_r",    cap[j].r,    tbl[j].exp_r);
            check("t1_i",    cap[j].i,    tbl[j].exp_i);
            check("t1_idx",  cap[j].idx,  tbl[j].exp_idx);
            check("t1_last", cap[j].last, tbl[j].exp_last);
        end
        check("t1_frame_err", bus.frame_err, 0);
        wait_idle();

        // Back-to-back three frames, no bubbles
        first_hs = -1;
        base_out = n_out;
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < N; j++) begin
                send(smp_t'(f * 1000 + j * 8), smp_t'(-(f * 100 + j)), j == N - 1, w);
                check("t2_in_ready_no_stall", w, 1);
            end
        end
        wait_idle();
        check("t2_output_count", n_out - base_out, 3 * N);
        check("t2_no_gaps",      last_hs - first_hs, 3 * N - 1);

        // Backpressure: both banks fill, then one drains
        bus.out_ready = 1'b0;
        acc_n = 0;
        k = 0;
        drive_k(k);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            a = bus.in_ready;
            @(posedge clk);
            #1;
            if (a) begin
                acc_n++;
                k++;
                drive_k(k);
            end
        end
        check("t3_accepts",     acc_n, 2 * N);
        check("t3_in_ready_lo", bus.in_ready, 0);
        check("t3_out_valid",   bus.out_valid, 1);
        check("t3_out_r_bin0",  bus.out_r, 0);
        check("t3_out_idx_bin0", bus.out_idx, 0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            check("t3_ready_low_drain", bus.in_ready, 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("t3_ready_returns", bus.in_ready, 1);
        @(posedge clk);
        #1;
        // The sample offered above was accepted on that edge.
        k++;
        drive_k(k);
        guard = 0;
        while (k < 3 * N && guard < 200) begin
            @(negedge clk);
            a = bus.in_ready;
            @(posedge clk);
            #1;
            if (a) begin
                k++;
                if (k < 3 * N) drive_k(k);
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        check("t3_all_sent", k, 3 * N);
        wait_idle();

        // Random gaps and random backpressure over 20 frames
        base_out = n_out;
        drv_done = 0;
        fork
            begin
                for (int f = 0; f < 20; f++) begin
                    for (int j = 0; j < N; j++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            @(posedge clk);
                            #1;
                        end
                        send(smp_t'($urandom), smp_t'($urandom), j == N - 1, w);
                    end
                end
                drv_done = 1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = $urandom_range(0, 1);
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_idle();
        check("t4_output_count", n_out - base_out, 20 * N);

        // Framing error: in_last at position 7
        base_out = n_out;
        check("t5_err_clear_before", bus.frame_err, 0);
        for (int j = 0; j < N; j++) begin
            send(smp_t'(j * 3), smp_t'(-j * 5), j == 7, w);
            if (j == 6) check("t5_err_not_yet", bus.frame_err, 0);
            if (j == 7) check("t5_err_set",     bus.frame_err, 1);
        end
        wait_idle();
        check("t5_err_sticky",   bus.frame_err, 1);
        check("t5_output_count", n_out - base_out, N);

        // Mid-frame reset with a complete frame pending
        bus.out_ready = 1'b0;
        for (int j = 0; j < N; j++) send(smp_t'(500 + j), smp_t'(j), j == N - 1, w);
        for (int j = 0; j < 9; j++) send(smp_t'(700 + j), smp_t'(j), 1'b0, w);
        check("t6_pending_valid", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", bus.out_valid, 0);
        check("t6_rst_out_r",     bus.out_r, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("t6_in_ready",  bus.in_ready, 1);
        check("t6_out_valid", bus.out_valid, 0);
        check("t6_frame_err", bus.frame_err, 0);
        check("t6_out_r",     bus.out_r, 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        base_out = n_out;
        for (int j = 0; j < N; j++) send(smp_t'(-300 + j * 7), smp_t'(j * 11), j == N - 1, w);
        wait_idle();
        check("t6_fresh_count", n_out - base_out, N);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output stage of the 16-point radix-2 FFT; consumes the last butterfly stage's complex results, which arrive in bit-reversed index order.
- Re-emits each frame in natural order (X[0]..X[N-1]).
- Ping-pong buffer of two N-entry banks, so one frame is written while the previous one drains.
- Valid/ready streaming on both sides, with a sticky framing-error flag.

Parameters:
- DATA_WIDTH, 16: bit width of each real/imag component (same as butterfly outputs).
- N_POINTS, 16: frame length; power of two, >= 4.
- LOG2N, 4: log2(N_POINTS); index/counter width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept an input sample.
- in_r  in  DATA_WIDTH  signed real part, bit-reversed order.
- in_i  in  DATA_WIDTH  signed imaginary part.
- in_last  in  1  marks the final sample of an input frame.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- out_r  out  DATA_WIDTH  signed real part, natural order.
- out_i  out  DATA_WIDTH  signed imaginary part.
- out_idx  out  LOG2N  natural-order bin index of the current output.
- out_last  out  1  high with the bin N_POINTS-1 output.
- frame_err  out  1  sticky framing error.

Behaviour:
- Reset (async assert, sync release): every output is 0 during reset, then out_valid=0, in_ready=1, out_r/out_i/out_idx=0, out_last=0, frame_err=0.
  - Reset also clears wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, full[1:0]=0 and all 2*N_POINTS storage entries.
  - Reset mid-frame discards all partial and complete frames.
- Input handshake: in_valid & in_ready.
  - Sample is stored in bank wr_bank at address bitrev(wr_cnt), where bit k of the address equals bit LOG2N-1-k of wr_cnt.
  - wr_cnt then increments.
  - When wr_cnt = N_POINTS-1 is accepted: wr_cnt wraps to 0, full[wr_bank] is set, wr_bank toggles.
- in_ready = !full[wr_bank], combinational from registers, with no dependence on in_valid or out_ready.
  - When both banks are full, in_ready=0.
  - A bank freed in cycle t (its last output accepted) gives in_ready=1 in cycle t+1. There is no same-cycle fall-through.
- Output:
  - out_valid = full[rd_bank].
  - out_r/out_i = bank rd_bank at address rd_cnt.
  - out_idx = rd_cnt.
  - out_last = out_valid & (rd_cnt == N_POINTS-1).
  - All outputs are driven from registers via the read mux only.
  - When out_valid=0, out_r/out_i show the addressed entry contents and are don't-care for checking, except after reset (0).
- Output handshake: out_valid & out_ready.
  - rd_cnt increments.
  - On rd_cnt = N_POINTS-1: rd_cnt wraps to 0, full[rd_bank] is cleared, rd_bank toggles.
- Latency: out_valid rises the cycle after the handshake of the N-th input sample of a frame, if that bank is next to read.
- Hold rules: while out_valid=1 and out_ready=0, out_r/out_i/out_idx/out_last are held stable. The write side never targets the bank being read.
- Simultaneous events: completing a write bank and draining the read bank in the same cycle are both applied. Their full-flag updates touch different banks and must not conflict.
- Throughput: with out_ready held high, sustained 1 sample/cycle in and out after a 16-cycle fill, with no bubbles.
- Framing check:
  - frame_err sets on any accepted input where in_last != (wr_cnt == N_POINTS-1).
  - frame_err stays set until reset.
  - Counting is unaffected: frames are delimited purely by wr_cnt, and in_last is advisory only.
- Arithmetic: no scaling, rounding or saturation; samples pass bit-exact.

Test Plan:
- Single frame:
  - Stimulus: reset; send in_r = k*8, in_i = -k, for stream position k = 0..15, with in_last at k=15; out_ready=1.
  - Required: out_valid rises one cycle after the 16th handshake; output j carries in_r = bitrev(j)*8 (j=1 -> 64, j=3 -> 96); out_last at j=15; frame_err=0.
- Back-to-back 3 frames, out_ready=1:
  - Required: in_ready stays 1 throughout; 48 outputs with no gaps after the first 16-cycle fill; order correct per frame.
- Backpressure, out_ready=0:
  - Stimulus: send 40 samples.
  - Required: in_ready drops after exactly 32 accepts; out_r/out_idx hold 0 at bin 0; after out_ready=1 for 16 cycles, in_ready returns the following cycle.
- Random out_ready (50%) with random in_valid gaps over 20 frames:
  - Required: scoreboard matches a natural-order reference; no sample lost or duplicated; outputs are stable while stalled.
- Framing error:
  - Stimulus: in_last asserted at position 7 of a frame.
  - Required: frame_err=1 the next cycle and stays 1; that frame still emits 16 outputs in correct order.
- Mid-frame reset:
  - Stimulus: assert rst_n=0 after 9 inputs of frame 2 with frame 1 pending output.
  - Required: out_valid=0 and in_ready=1 immediately; a fresh frame after reset is emitted correctly, with no stale data.
